// File: rtl/snow64_bfloat16_fpu_arbiter.sv
// snow64_bfloat16_fpu_arbiter
//
// Shares one Snow64BFloat16Fpu between NUM_REQ requesters. In ST_IDLE it picks
// the first pending request round-robin from ptr and issues it to the FPU in
// the same cycle. It then waits in ST_WAIT for the single in-flight operation.
// The result is routed back to the owner as a one-cycle pulse. A watchdog
// retires an operation the FPU never completes and flags it as timed out.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_req_valid           per-requester pending flag (held until granted)
//   in_req_oper/a/b        per-requester opcode/operands, slot i at [i*W +: W]
//   out_req_grant          one-hot pulse, request consumed this cycle
//   out_rsp_valid          one-hot pulse, result for requester i
//   out_rsp_data           result (0 on watchdog retire)
//   out_rsp_timeout        qualifies out_rsp_valid: retired by watchdog
//   out_fpu_start/oper/a/b FPU command inputs
//   in_fpu_data_valid, in_fpu_can_accept_cmd, in_fpu_data   FPU outputs
module snow64_bfloat16_fpu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int OPER_WIDTH     = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            in_req_valid,
  input  logic [NUM_REQ*OPER_WIDTH-1:0] in_req_oper,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_b,
  output logic [NUM_REQ-1:0]            out_req_grant,
  output logic [NUM_REQ-1:0]            out_rsp_valid,
  output logic [DATA_WIDTH-1:0]         out_rsp_data,
  output logic                          out_rsp_timeout,
  output logic                          out_fpu_start,
  output logic [OPER_WIDTH-1:0]         out_fpu_oper,
  output logic [DATA_WIDTH-1:0]         out_fpu_a,
  output logic [DATA_WIDTH-1:0]         out_fpu_b,
  input  logic                          in_fpu_data_valid,
  input  logic                          in_fpu_can_accept_cmd,
  input  logic [DATA_WIDTH-1:0]         in_fpu_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                  state_reg, state_next;
  logic [PTR_W-1:0]        ptr_reg, ptr_next;
  logic [PTR_W-1:0]        owner_reg, owner_next;
  logic [WD_W-1:0]         wd_reg, wd_next;
  logic [NUM_REQ-1:0]      rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0]   rsp_data_reg, rsp_data_next;
  logic                    rsp_timeout_reg, rsp_timeout_next;

  logic [PTR_W-1:0]        winner;
  logic                    winner_found;
  logic                    issue;
  logic                    done;
  logic                    expire;

  // Unpack the flat request buses into per-slot arrays.
  logic [OPER_WIDTH-1:0] req_oper [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_a    [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_b    [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign req_oper[gi] = in_req_oper[gi*OPER_WIDTH +: OPER_WIDTH];
      assign req_a[gi]    = in_req_a[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_b[gi]    = in_req_b[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Round-robin pick: scan from the highest offset down so that the
  // smallest offset from ptr is the last (and therefore winning) assignment.
  always_comb begin
    logic [PTR_W-1:0] cand;
    winner       = '0;
    winner_found = 1'b0;
    cand         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (in_req_valid[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  // Issue is gated by rst so nothing leaks to the FPU during the reset cycle.
  assign issue  = (state_reg == ST_IDLE) && !rst && winner_found && in_fpu_can_accept_cmd;
  assign done   = (state_reg == ST_WAIT) && in_fpu_data_valid && in_fpu_can_accept_cmd;
  assign expire = (state_reg == ST_WAIT) && !done && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      ptr_reg         <= '0;
      owner_reg       <= '0;
      wd_reg          <= '0;
      rsp_valid_reg   <= '0;
      rsp_data_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      owner_reg       <= owner_next;
      wd_reg          <= wd_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  // Next-state logic. Response registers default to zero so every
  // response is a single-cycle pulse.
  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    owner_next       = owner_reg;
    wd_next          = wd_reg;
    rsp_valid_next   = '0;
    rsp_data_next    = '0;
    rsp_timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (issue) begin
          owner_next = winner;
          ptr_next   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
          wd_next    = '0;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done) begin
          rsp_valid_next = NUM_REQ'(1) << owner_reg;
          rsp_data_next  = in_fpu_data;
          state_next     = ST_IDLE;
        end else if (expire) begin
          rsp_valid_next   = NUM_REQ'(1) << owner_reg;
          rsp_timeout_next = 1'b1;
          state_next       = ST_IDLE;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: FPU command and grant are combinational on the issue decision,
  // the response side comes straight from registers.
  always_comb begin
    out_fpu_start   = issue;
    out_fpu_oper    = '0;
    out_fpu_a       = '0;
    out_fpu_b       = '0;
    out_req_grant   = '0;
    if (issue) begin
      out_fpu_oper  = req_oper[winner];
      out_fpu_a     = req_a[winner];
      out_fpu_b     = req_b[winner];
      out_req_grant = NUM_REQ'(1) << winner;
    end
    out_rsp_valid   = rsp_valid_reg;
    out_rsp_data    = rsp_data_reg;
    out_rsp_timeout = rsp_timeout_reg;
  end

endmodule

// File: tb/tb_snow64_bfloat16_fpu_arbiter.sv
// Directed bench for snow64_bfloat16_fpu_arbiter with a small behavioural
// FPU model (fixed latency, table of known bfloat16 results, SUB performed
// as ADD with negated b inside the FPU).
module tb_snow64_bfloat16_fpu_arbiter;

  localparam int N   = 4;
  localparam int OW  = 3;
  localparam int DW  = 16;
  localparam int TO  = 64;
  localparam int LAT = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLT = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*OW-1:0] req_oper = '0;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]    req_grant;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_timeout;
  logic            fpu_start;
  logic [OW-1:0]   fpu_oper;
  logic [DW-1:0]   fpu_a, fpu_b;
  logic            fpu_data_valid;
  logic            fpu_can_accept;
  logic [DW-1:0]   fpu_data;

  logic            fpu_hang = 1'b0;
  logic            fpu_block = 1'b0;
  logic            fb_busy = 1'b0;
  int              fb_cnt = 0;
  logic [DW-1:0]   fb_res = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snow64_bfloat16_fpu_arbiter #(
    .NUM_REQ(N), .OPER_WIDTH(OW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_req_valid(req_valid),
    .in_req_oper(req_oper),
    .in_req_a(req_a),
    .in_req_b(req_b),
    .out_req_grant(req_grant),
    .out_rsp_valid(rsp_valid),
    .out_rsp_data(rsp_data),
    .out_rsp_timeout(rsp_timeout),
    .out_fpu_start(fpu_start),
    .out_fpu_oper(fpu_oper),
    .out_fpu_a(fpu_a),
    .out_fpu_b(fpu_b),
    .in_fpu_data_valid(fpu_data_valid),
    .in_fpu_can_accept_cmd(fpu_can_accept),
    .in_fpu_data(fpu_data)
  );

  // Hand-computed bfloat16 results for the vectors used here.
  function automatic logic [DW-1:0] fpu_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (a == 16'h3F80 && b == 16'h4000) return 16'h4040;  // 1 + 2 = 3
    if (a == 16'h4000 && b == 16'hBF80) return 16'h3F80;  // 2 + (-1) = 1
    return 16'hDEAD;
  endfunction

  function automatic logic [DW-1:0] fpu_calc(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    case (op)
      OP_ADD: return fpu_add(a, b);
      OP_SUB: return fpu_add(a, b ^ 16'h8000);
      OP_SLT: return (a == 16'h3F80 && b == 16'h4000) ? 16'h0001 : 16'hDEAD;
      OP_MUL: return (a == 16'h4000 && b == 16'h4000) ? 16'h4080 : 16'hDEAD;
      OP_DIV: return (a == 16'h4000 && b == 16'h4000) ? 16'h3F80 : 16'hDEAD;
      default: return 16'hDEAD;
    endcase
  endfunction

  // FPU model: no reset, LAT cycles from start to data_valid.
  always @(posedge clk) begin
    if (fpu_start) begin
      fb_busy <= 1'b1;
      fb_cnt  <= LAT - 1;
      fb_res  <= fpu_calc(fpu_oper, fpu_a, fpu_b);
    end else if (fb_busy) begin
      if (fb_cnt > 0) fb_cnt <= fb_cnt - 1;
      else if (!fpu_hang) fb_busy <= 1'b0;
    end
  end

  assign fpu_data_valid = fb_busy && (fb_cnt == 0) && !fpu_hang;
  assign fpu_can_accept = (!fb_busy || fb_cnt == 0) && !fpu_block;
  assign fpu_data       = fpu_data_valid ? fb_res : 16'h0000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    req_oper[i*OW +: OW] = op;
    req_a[i*DW +: DW]    = a;
    req_b[i*DW +: DW]    = b;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_req(0, OP_ADD, 16'h3F80, 16'h4000);
    req_valid = 4'b0001;
    tick();
    checks++;
    if (req_grant !== 4'b0000 || fpu_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_grant: grant=%b start=%b required grant=0000 start=0", req_grant, fpu_start);
    end
    req_valid = '0;
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 16'h0000 || rsp_timeout !== 1'b0 ||
        fpu_oper !== 3'd0 || fpu_a !== 16'h0000 || fpu_b !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: rsp=%b data=%h to=%b oper=%0d a=%h b=%h required all 0",
               rsp_valid, rsp_data, rsp_timeout, fpu_oper, fpu_a, fpu_b);
    end
    $display("test_reset: done");
  endtask

  task automatic test_single_add;
    int n;
    set_req(0, OP_ADD, 16'h3F80, 16'h4000);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_grant !== 4'b0001 || fpu_start !== 1'b1 || fpu_oper !== OP_ADD ||
        fpu_a !== 16'h3F80 || fpu_b !== 16'h4000) begin
      errors++;
      $display("FAIL add_issue: grant=%b start=%b oper=%0d a=%h b=%h required 0001 1 0 3f80 4000",
               req_grant, fpu_start, fpu_oper, fpu_a, fpu_b);
    end
    tick();
    req_valid = '0;
    n = 1;
    while (rsp_valid === 4'b0000 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== LAT + 1 || rsp_valid !== 4'b0001 || rsp_data !== 16'h4040 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL add_rsp: latency=%0d rsp=%b data=%h to=%b required %0d 0001 4040 0",
               n, rsp_valid, rsp_data, rsp_timeout, LAT + 1);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL add_pulse_width: rsp=%b required 0000", rsp_valid);
    end
    $display("test_single_add: latency %0d data %h", n, 16'h4040);
  endtask

  task automatic test_round_robin;
    int gcount;
    int rcount;
    logic [N-1:0] granted;
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, OP_MUL, 16'h4000, 16'h4000);
    req_valid = 4'b1111;
    tick();
    rst = 1'b0;
    #1;
    gcount = 0;
    rcount = 0;
    for (int c = 0; c < 100 && rcount < N; c++) begin
      if (req_grant !== 4'b0000) begin
        checks++;
        if (gcount >= N || req_grant !== (4'(1) << gcount) || fpu_oper !== OP_MUL ||
            fpu_a !== 16'h4000 || fpu_b !== 16'h4000) begin
          errors++;
          $display("FAIL rr_grant: grant#%0d=%b oper=%0d a=%h b=%h required %b 3 4000 4000",
                   gcount, req_grant, fpu_oper, fpu_a, fpu_b, 4'(1) << gcount);
        end
        $display("test_round_robin: grant %b", req_grant);
        gcount++;
      end
      if (rsp_valid !== 4'b0000) begin
        checks++;
        if (rsp_valid !== (4'(1) << rcount) || rsp_data !== 16'h4080 || rsp_timeout !== 1'b0) begin
          errors++;
          $display("FAIL rr_rsp: rsp#%0d=%b data=%h to=%b required %b 4080 0",
                   rcount, rsp_valid, rsp_data, rsp_timeout, 4'(1) << rcount);
        end
        rcount++;
      end
      granted = req_grant;
      tick();
      req_valid = req_valid & ~granted;
      #1;
    end
    checks++;
    if (gcount !== N || rcount !== N) begin
      errors++;
      $display("FAIL rr_count: grants=%0d rsps=%0d required %0d %0d", gcount, rcount, N, N);
    end
  endtask

  task automatic test_pointer_wrap;
    int n;
    set_req(2, OP_ADD, 16'h3F80, 16'h4000);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_grant !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_grant2: grant=%b required 0100", req_grant);
    end
    tick();
    set_req(0, OP_ADD, 16'h3F80, 16'h4000);
    req_valid = 4'b0001;
    #1;
    n = 0;
    while (rsp_valid === 4'b0000 && n < 100) begin
      checks++;
      if (req_grant !== 4'b0000) begin
        errors++;
        $display("FAIL wait_no_grant: grant=%b in wait cycle %0d required 0000", req_grant, n);
      end
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 16'h4040 || req_grant !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_rsp2: rsp=%b data=%h grant=%b required 0100 4040 0001",
               rsp_valid, rsp_data, req_grant);
    end
    tick();
    req_valid = '0;
    n = 0;
    while (rsp_valid === 4'b0000 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 16'h4040) begin
      errors++;
      $display("FAIL wrap_rsp0: rsp=%b data=%h required 0001 4040", rsp_valid, rsp_data);
    end
    tick();
    $display("test_pointer_wrap: req2 then req0 served");
  endtask

  task automatic test_timeout;
    int n;
    fpu_hang = 1'b1;
    set_req(1, OP_ADD, 16'h3F80, 16'h4000);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_grant !== 4'b0010) begin
      errors++;
      $display("FAIL to_grant: grant=%b required 0010", req_grant);
    end
    tick();
    req_valid = '0;
    n = 1;
    while (rsp_valid === 4'b0000 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n !== TO + 1 || rsp_valid !== 4'b0010 || rsp_timeout !== 1'b1 || rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL to_rsp: cycles=%0d rsp=%b to=%b data=%h required %0d 0010 1 0000",
               n, rsp_valid, rsp_timeout, rsp_data, TO + 1);
    end
    fpu_hang = 1'b0;
    tick();
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_grant !== 4'b0010 || fpu_start !== 1'b1) begin
      errors++;
      $display("FAIL to_reissue: grant=%b start=%b required 0010 1", req_grant, fpu_start);
    end
    tick();
    req_valid = '0;
    n = 0;
    while (rsp_valid === 4'b0000 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 16'h4040 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_after: rsp=%b data=%h to=%b required 0010 4040 0", rsp_valid, rsp_data, rsp_timeout);
    end
    tick();
    $display("test_timeout: retired after %0d cycles", TO + 1);
  endtask

  task automatic test_reset_mid_op;
    int n;
    set_req(0, OP_DIV, 16'h4000, 16'h4000);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_grant !== 4'b0001 || fpu_oper !== OP_DIV) begin
      errors++;
      $display("FAIL div_issue: grant=%b oper=%0d required 0001 4", req_grant, fpu_oper);
    end
    tick();
    req_valid = '0;
    rst = 1'b1;
    fpu_block = 1'b1;
    set_req(1, OP_ADD, 16'h3F80, 16'h4000);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_grant !== 4'b0000 || fpu_start !== 1'b0) begin
      errors++;
      $display("FAIL midrst_grant: grant=%b start=%b required 0000 0", req_grant, fpu_start);
    end
    tick();
    rst = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (req_grant !== 4'b0000 || fpu_start !== 1'b0 || rsp_valid !== 4'b0000 ||
          rsp_data !== 16'h0000 || fpu_a !== 16'h0000) begin
        errors++;
        $display("FAIL midrst_quiet: cycle %0d grant=%b start=%b rsp=%b data=%h a=%h required all 0",
                 c, req_grant, fpu_start, rsp_valid, rsp_data, fpu_a);
      end
      tick();
    end
    fpu_block = 1'b0;
    #1;
    checks++;
    if (req_grant !== 4'b0010 || fpu_start !== 1'b1) begin
      errors++;
      $display("FAIL midrst_issue: grant=%b start=%b required 0010 1", req_grant, fpu_start);
    end
    tick();
    req_valid = '0;
    n = 0;
    while (rsp_valid === 4'b0000 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 16'h4040) begin
      errors++;
      $display("FAIL midrst_rsp: rsp=%b data=%h required 0010 4040", rsp_valid, rsp_data);
    end
    tick();
    $display("test_reset_mid_op: div dropped, req1 served");
  endtask

  task automatic test_back_to_back;
    int n;
    set_req(2, OP_SLT, 16'h3F80, 16'h4000);
    set_req(3, OP_SUB, 16'h4000, 16'h3F80);
    req_valid = 4'b1100;
    #1;
    checks++;
    if (req_grant !== 4'b0100 || fpu_oper !== OP_SLT) begin
      errors++;
      $display("FAIL b2b_slt_issue: grant=%b oper=%0d required 0100 2", req_grant, fpu_oper);
    end
    tick();
    req_valid = 4'b1000;
    #1;
    n = 0;
    while (rsp_valid === 4'b0000 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 16'h0001 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_slt_rsp: rsp=%b data=%h to=%b required 0100 0001 0", rsp_valid, rsp_data, rsp_timeout);
    end
    checks++;
    if (req_grant !== 4'b1000 || fpu_start !== 1'b1 || fpu_oper !== OP_SUB ||
        fpu_a !== 16'h4000 || fpu_b !== 16'h3F80) begin
      errors++;
      $display("FAIL b2b_sub_issue: grant=%b start=%b oper=%0d a=%h b=%h required 1000 1 1 4000 3f80",
               req_grant, fpu_start, fpu_oper, fpu_a, fpu_b);
    end
    tick();
    req_valid = '0;
    n = 0;
    while (rsp_valid === 4'b0000 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_data !== 16'h3F80) begin
      errors++;
      $display("FAIL b2b_sub_rsp: rsp=%b data=%h required 1000 3f80", rsp_valid, rsp_data);
    end
    tick();
    $display("test_back_to_back: slt then sub");
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_pointer_wrap();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
